inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_pkg.sv | 12 +
 rtl/inst_buffer_compact.sv | 22 ++
 rtl/inst_buffer.sv | 82 ++++++++
 tb/tb_inst_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared widths and entry type for the instruction buffer
package inst_buffer_pkg;
    localparam int XLEN         = 32;
    localparam int FETCH_WIDTH  = 4;
    localparam int DECODE_WIDTH = 2;
    localparam int IBUF_DEPTH   = 16;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } ibuf_entry_t;
endpackage

// File: rtl/inst_buffer_compact.sv
// rtl/inst_buffer_compact.sv - prefix popcount of a fetch mask giving per-slot write offsets
module inst_compact
    import inst_buffer_pkg::*;
#(
    parameter  int WIDTH = inst_buffer_pkg::FETCH_WIDTH,
    localparam int OW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]         mask,
    output logic [WIDTH-1:0][OW-1:0] offset,
    output logic [OW-1:0]            total
);

    // offset[i] counts the set mask bits strictly below slot i
    always_comb begin
        total = '0;
        for (int i = 0; i < WIDTH; i++) begin
            offset[i] = total;
            total     = total + OW'(mask[i]);
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - circular instruction buffer between fetch and decode
module inst_buffer #(
    parameter int FETCH_WIDTH  = inst_buffer_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = inst_buffer_pkg::DECODE_WIDTH,
    parameter int DEPTH        = inst_buffer_pkg::IBUF_DEPTH
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              fetch_valid,
    input  logic [FETCH_WIDTH-1:0]                            fetch_mask,
    input  logic [FETCH_WIDTH-1:0][31:0]                      fetch_inst,
    input  logic [inst_buffer_pkg::XLEN-1:0]                  fetch_pc,
    output logic                                              fetch_ready,
    input  logic                                              flush,
    output logic [DECODE_WIDTH-1:0]                           dec_valid,
    output logic [DECODE_WIDTH-1:0][31:0]                     dec_inst,
    output logic [DECODE_WIDTH-1:0][inst_buffer_pkg::XLEN-1:0] dec_pc,
    input  logic                                              dec_ready
);
    import inst_buffer_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(FETCH_WIDTH + 1);

    ibuf_entry_t                   mem [DEPTH];
    logic [AW-1:0]                 head, tail;
    logic [CW-1:0]                 count, count_nxt, enq_cnt, deq_cnt;
    logic                          fire;
    logic [FETCH_WIDTH-1:0][OW-1:0] offset;
    logic [OW-1:0]                 total;

    inst_compact #(.WIDTH(FETCH_WIDTH)) u_compact (
        .mask   (fetch_mask),
        .offset (offset),
        .total  (total)
    );

    assign fire      = fetch_valid && fetch_ready;
    assign enq_cnt   = fire ? CW'(total) : '0;
    assign deq_cnt   = !dec_ready ? '0 :
                       (count > CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : count;
    assign count_nxt = count + enq_cnt - deq_cnt;

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            dec_valid[i] = count > CW'(i);
            dec_inst[i]  = mem[head + AW'(i)].inst;
            dec_pc[i]    = mem[head + AW'(i)].pc;
        end
    end

    // fetch_ready is a registered view of the occupancy the next cycle starts with
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_ready <= 1'b1;
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (fire && fetch_mask[i]) begin
                    mem[tail + AW'(offset[i])] <= '{inst: fetch_inst[i],
                                                    pc:   fetch_pc + XLEN'(4 * i)};
                end
            end
            head        <= head + AW'(deq_cnt);
            tail        <= tail + AW'(enq_cnt);
            count       <= count_nxt;
            fetch_ready <= (CW'(DEPTH) - count_nxt) >= CW'(FETCH_WIDTH);
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - scoreboard bench for inst_buffer
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int FW = 4;
    localparam int DW = 2;

    logic                    clk = 1'b0;
    logic                    rst, fetch_valid, flush, dec_ready;
    logic [FW-1:0]           fetch_mask;
    logic [FW-1:0][31:0]     fetch_inst;
    logic [XLEN-1:0]         fetch_pc;
    logic                    fetch_ready;
    logic [DW-1:0]           dec_valid;
    logic [DW-1:0][31:0]     dec_inst;
    logic [DW-1:0][XLEN-1:0] dec_pc;

    inst_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_mask  (fetch_mask),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready)
    );

    always #5 clk = ~clk;

    ibuf_entry_t         sb [$];
    ibuf_entry_t         mon_e;
    int                  errors = 0;
    int                  checks = 0;
    logic                mon_en = 1'b0;
    int                  bundle_id = 0;
    logic                st_acc, st_fl;
    logic [FW-1:0]       st_m;
    logic [31:0]         st_pc;
    logic [FW-1:0][31:0] st_inst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode-side monitor: occupancy against the model, then pop what decode takes
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int i = 0; i < DW; i++) check("dec_valid_vs_model", 64'(dec_valid[i]), 64'(sb.size() > i));
            if (dec_ready && !flush) begin
                for (int i = 0; i < DW; i++) begin
                    if (dec_valid[i]) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: pc %h with empty model", dec_pc[i]);
                        end else begin
                            mon_e = sb.pop_front();
                            check("dec_inst", 64'(dec_inst[i]), 64'(mon_e.inst));
                            check("dec_pc", 64'(dec_pc[i]), 64'(mon_e.pc));
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input logic fv, input logic [FW-1:0] m, input logic [31:0] pc,
                       input logic dr, input logic fl);
        fetch_valid = fv;
        fetch_mask  = m;
        fetch_pc    = pc;
        dec_ready   = dr;
        flush       = fl;
        for (int i = 0; i < FW; i++) fetch_inst[i] = 32'hC0DE_0000 + 32'(bundle_id * 16 + i);
        @(negedge clk);
        st_acc  = fv && fetch_ready && !fl;
        st_fl   = fl;
        st_m    = m;
        st_pc   = pc;
        st_inst = fetch_inst;
    endtask

    task automatic tick();
        @(posedge clk);
        if (st_fl) begin
            sb.delete();
        end else if (st_acc) begin
            for (int i = 0; i < FW; i++)
                if (st_m[i]) sb.push_back('{inst: st_inst[i], pc: st_pc + 32'(4 * i)});
            bundle_id++;
        end
        #1;
    endtask

    task automatic step(input logic fv, input logic [FW-1:0] m, input logic [31:0] pc,
                        input logic dr, input logic fl);
        cyc(fv, m, pc, dr, fl);
        tick();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    logic [3:0] masks [8] = '{4'b1111, 4'b1010, 4'b0001, 4'b0110, 4'b0000, 4'b1101, 4'b1000, 4'b0111};
    int n, b;

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_mask = '0; fetch_pc = '0;
        fetch_inst = '0; flush = 1'b0; dec_ready = 1'b0;
        st_acc = 1'b0; st_fl = 1'b0; st_m = '0; st_pc = '0; st_inst = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_dec_valid", 64'(dec_valid), 64'd0);
        check("reset_fetch_ready", 64'(fetch_ready), 64'd1);
        check("reset_dec_inst", 64'(dec_inst), 64'd0);
        check("reset_dec_pc", 64'(dec_pc), 64'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // One full bundle, two cycles of decode, no bypass
        cyc(1'b1, 4'b1111, 32'h1000, 1'b1, 1'b0);
        check("no_bypass", 64'(dec_valid), 64'd0);
        tick();
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("b1_pc0", 64'(dec_pc[0]), 64'h1000);
        check("b1_pc1", 64'(dec_pc[1]), 64'h1004);
        tick();
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("b1_pc2", 64'(dec_pc[0]), 64'h1008);
        check("b1_pc3", 64'(dec_pc[1]), 64'h100C);
        tick();
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("b1_empty", 64'(dec_valid), 64'd0);
        tick();

        // Sparse mask compaction
        step(1'b1, 4'b1010, 32'h2000, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("sparse_valid", 64'(dec_valid), 64'h3);
        check("sparse_pc0", 64'(dec_pc[0]), 64'h2004);
        check("sparse_pc1", 64'(dec_pc[1]), 64'h200C);
        tick();
        step(1'b1, 4'b1111, 32'hFFFF_FFF8, 1'b1, 1'b0);
        drain("pc_wrap_drain");

        // Fill with decode stalled; fetch_valid held past the point of refusal
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 4'b1111, 32'h3000 + 32'(k * 16), 1'b0, 1'b0);
            if (st_acc) n++;
            tick();
        end
        check("fill_bundles", 64'(n), 64'd4);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        check("full_not_ready", 64'(fetch_ready), 64'd0);
        tick();
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            if (k == 1) check("ready_at_14", 64'(fetch_ready), 64'd0);
            if (k == 2) check("ready_at_12", 64'(fetch_ready), 64'd1);
            tick();
        end
        check("fill_drained", 64'(sb.size()), 64'd0);

        // Long wrap run with toggling decode
        b = 0;
        for (int k = 0; k < 400 && b < 48; k++) begin
            cyc(1'b1, masks[b % 8], 32'h4000 + 32'(b * 16), (k % 3) != 0, 1'b0);
            if (st_acc) b++;
            tick();
        end
        check("wrap_bundles", 64'(b), 64'd48);
        drain("wrap_drain");

        // Flush racing an accepted-looking fetch and decode
        step(1'b1, 4'b1111, 32'h5000, 1'b0, 1'b0);
        cyc(1'b1, 4'b1111, 32'h6000, 1'b1, 1'b1);
        check("flush_pre_ready", 64'(fetch_ready), 64'd1);
        tick();
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        check("flush_valid", 64'(dec_valid), 64'd0);
        check("flush_ready", 64'(fetch_ready), 64'd1);
        tick();
        step(1'b1, 4'b0011, 32'h7000, 1'b1, 1'b0);
        drain("post_flush_drain");

        // Reset with nine entries held
        step(1'b1, 4'b1111, 32'h8000, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 32'h8010, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 32'h8020, 1'b0, 1'b0);
        check("nine_held", 64'(sb.size()), 64'd9);
        rst = 1'b1; fetch_valid = 1'b1; fetch_mask = 4'b1111; dec_ready = 1'b1;
        @(posedge clk);
        sb.delete();
        #1 rst = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(dec_valid), 64'd0);
        check("rst_inst", 64'(dec_inst), 64'd0);
        check("rst_ready", 64'(fetch_ready), 64'd1);
        @(posedge clk);
        #1;
        step(1'b1, 4'b0101, 32'h9000, 1'b1, 1'b0);
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
